// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: size encodings,
// FSM state type and the alignment rule.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_t;

  // Reserved size (2'b11) is reported as not aligned so it takes the error path.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the EX/MEM pipeline register and the
// load/store unit.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit_align.sv
// Big-endian byte-lane steering: load extract/extend and sub-word store merge.
// Purely combinational.
module byte_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] rd_word,
  output logic [31:0] ld_data,
  input  logic [31:0] old_word,
  input  logic [31:0] st_data,
  output logic [31:0] merged
);

  // Byte 0 sits in [31:24], so the right-shift to the lane is (3 - addr_lo) * 8.
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] byte_shifted;
  logic [31:0] half_shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_sh      = {~addr_lo, 3'b000};
  assign half_sh      = {~addr_lo[1], 4'b0000};
  assign byte_shifted = rd_word >> byte_sh;
  assign half_shifted = rd_word >> half_sh;
  assign byte_v       = byte_shifted[7:0];
  assign half_v       = half_shifted[15:0];

  // Load path: pick the addressed lane and extend to a full word.
  always_comb begin
    ld_data = '0;
    case (size)
      SZ_BYTE: ld_data = is_signed ? {{24{byte_v[7]}}, byte_v} : {24'h000000, byte_v};
      SZ_HALF: ld_data = is_signed ? {{16{half_v[15]}}, half_v} : {16'h0000, half_v};
      SZ_WORD: ld_data = rd_word;
      default: ld_data = '0;
    endcase
  end

  // Store path: replace only the addressed lane(s) of the old word.
  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged = (old_word & ~(32'h000000FF << byte_sh)) |
                        ({24'h000000, st_data[7:0]} << byte_sh);
      SZ_HALF: merged = (old_word & ~(32'h0000FFFF << half_sh)) |
                        ({16'h0000, st_data[15:0]} << half_sh);
      SZ_WORD: merged = st_data;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-addressed data memory.
// Loads and word stores complete in one cycle; byte/half stores are a
// read-modify-write spanning the accept cycle and one RMW_WR cycle.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_access_unit_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("mem_access_unit: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH < 3) begin : g_bad_addr_width
    $error("mem_access_unit: ADDR_WIDTH must be at least 3");
  end

  state_t                state_q, state_d;
  logic                  accept;
  logic                  aligned;
  logic                  go;
  logic                  sub_store;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic [ADDR_WIDTH-1:0] rmw_addr_q;
  logic [31:0]           merge_q;
  logic [31:0]           ld_data;
  logic [31:0]           merged;

  assign accept    = bus.req_valid && (state_q == IDLE);
  assign aligned   = is_aligned(bus.req_size, bus.req_addr[1:0]);
  assign go        = accept && aligned;
  assign sub_store = bus.req_store && (bus.req_size != SZ_WORD);
  assign word_addr = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};

  byte_lane_align u_align (
    .addr_lo   (bus.req_addr[1:0]),
    .size      (bus.req_size),
    .is_signed (bus.req_signed),
    .rd_word   (mem_rdata),
    .ld_data   (ld_data),
    .old_word  (mem_rdata),
    .st_data   (bus.req_wdata),
    .merged    (merged)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: only an aligned sub-word store leaves IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go && sub_store) state_d = RMW_WR;
      RMW_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port and ready, combinational from state and the live request.
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    mem_cs        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = last_addr_q;
    mem_wdata     = merge_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          mem_cs   = 1'b1;
          mem_addr = word_addr;
          if (bus.req_store && !sub_store) begin
            mem_we    = 1'b1;
            mem_wdata = bus.req_wdata;
          end
        end
      end
      RMW_WR: begin
        mem_cs   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = rmw_addr_q;
        mem_wdata = merge_q;
      end
      default: ;
    endcase
  end

  // Response registers, RMW merge state and the held memory address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      merge_q       <= '0;
      rmw_addr_q    <= '0;
      last_addr_q   <= '0;
    end else begin
      if (mem_cs) last_addr_q <= mem_addr;
      if (go && sub_store) begin
        merge_q    <= merged;
        rmw_addr_q <= word_addr;
      end
      bus.rsp_valid <= (accept && !(aligned && sub_store)) || (state_q == RMW_WR);
      bus.rsp_err   <= accept && !aligned;
      bus.rsp_rdata <= (go && !bus.req_store) ? ld_data : '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural word memory and a
// big-endian byte-array reference model.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_cs, mem_we;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .mem_addr  (mem_addr),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Word memory: combinational read, write on rising edge; preload port for setup.
  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_cs && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  logic [7:0] ref_mem [0:255];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int passes = 0;
  int last_stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = ref_mem[a[7:0]];
    b1 = ref_mem[a[7:0] + 8'd1];
    b2 = ref_mem[a[7:0] + 8'd2];
    b3 = ref_mem[a[7:0] + 8'd3];
    case (sz)
      SZ_BYTE: return sg ? {{24{b0[7]}}, b0} : {24'h0, b0};
      SZ_HALF: return sg ? {{16{b0[7]}}, b0, b1} : {16'h0, b0, b1};
      SZ_WORD: return {b0, b1, b2, b3};
      default: return 32'h0;
    endcase
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    case (sz)
      SZ_BYTE: ref_mem[a[7:0]] = wd[7:0];
      SZ_HALF: begin
        ref_mem[a[7:0]]        = wd[15:8];
        ref_mem[a[7:0] + 8'd1] = wd[7:0];
      end
      default: begin
        ref_mem[a[7:0]]        = wd[31:24];
        ref_mem[a[7:0] + 8'd1] = wd[23:16];
        ref_mem[a[7:0] + 8'd2] = wd[15:8];
        ref_mem[a[7:0] + 8'd3] = wd[7:0];
      end
    endcase
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = a[7:2]; pl_data = w;
    ref_store(SZ_WORD, a, w);
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Drive one request at a falling edge, wait (bounded) for ready, queue the expectation.
  task automatic issue(input logic st, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input bit want_rsp);
    int   waits;
    exp_t e;
    waits = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    while (!bus.req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    last_stalls = waits;
    if (!bus.req_ready) begin
      checks++;
      $display("FAIL accept_timeout: got req_ready=0 for %0d cycles, required acceptance", waits);
      bus.req_valid = 1'b0;
      return;
    end
    if (exp_err) begin
      #1;
      check("err_no_mem_access", {30'h0, mem_cs, mem_we}, 32'h0);
    end
    if (want_rsp) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.due   = cyc + ((st && sz != SZ_WORD && !exp_err) ? 2 : 1);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Monitor: pop and compare on every response; flag late or unexpected ones.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.rsp_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=%h err=%b, required no response",
                   bus.rsp_rdata, bus.rsp_err);
        end else begin
          e = sb_q.pop_front();
          if (bus.rsp_rdata === e.rdata && bus.rsp_err === e.err && cyc == e.due) passes++;
          else $display("FAIL rsp: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                        bus.rsp_rdata, bus.rsp_err, cyc, e.rdata, e.err, e.due);
        end
      end else if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        checks++;
        $display("FAIL rsp_missing: got no rsp_valid by cycle %0d, required rdata=%h err=%b at cycle %0d",
                 cyc, sb_q[0].rdata, sb_q[0].err, sb_q[0].due);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    int drain;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int unsigned i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    preload(32'h10, 32'h11223344);
    preload(32'h20, 32'h80FF7F01);
    preload(32'h30, 32'hCAFEF00D);

    @(negedge clk);
    check("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    check("reset_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("reset_mem_we", {31'h0, mem_we}, 32'h0);
    rst_n = 1'b1;

    issue(1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 32'h00000022, 1'b0, 1'b1);
    issue(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 32'h00003344, 1'b0, 1'b1);
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, 1'b1);
    issue(1'b0, SZ_BYTE, 1'b1, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h20, 32'h0, 32'h00000080, 1'b0, 1'b1);
    issue(1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0, 32'hFFFF80FF, 1'b0, 1'b1);

    // Reset during RMW_WR abandons the write and its response.
    issue(1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h55, 32'h0, 1'b0, 1'b0);
    check("rmw_we_active", {31'h0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rmw_reset_we_drop", {31'h0, mem_we}, 32'h0);
    check("rmw_reset_ready", {31'h0, bus.req_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    check("rmw_reset_word_kept", mem[4], 32'h11223344);
    check("post_reset_ready", {31'h0, bus.req_ready}, 32'h1);

    ref_store(SZ_BYTE, 32'h13, 32'hAB);
    issue(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'hAB, 32'h0, 1'b0, 1'b1);
    check("sb_ready_low", {31'h0, bus.req_ready}, 32'h0);
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h112233AB, 1'b0, 1'b1);
    check("sb_stall_cycles", last_stalls, 32'd1);
    ref_store(SZ_HALF, 32'h10, 32'hBEEF);
    issue(1'b1, SZ_HALF, 1'b0, 32'h10, 32'hBEEF, 32'h0, 1'b0, 1'b1);
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hBEEF33AB, 1'b0, 1'b1);

    issue(1'b0, SZ_HALF, 1'b1, 32'h11, 32'h0, 32'h0, 1'b1, 1'b1);
    issue(1'b1, SZ_WORD, 1'b0, 32'h12, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    check("err_word_unchanged", mem[4], 32'hBEEF33AB);

    // Back-to-back stream on one word against the byte-array model.
    ref_store(SZ_WORD, 32'h30, 32'h0A0B0C0D);
    issue(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h0A0B0C0D, 32'h0, 1'b0, 1'b1);
    issue(1'b0, SZ_BYTE, 1'b1, 32'h31, 32'h0, ref_load(SZ_BYTE, 1'b1, 32'h31), 1'b0, 1'b1);
    ref_store(SZ_BYTE, 32'h32, 32'h99);
    issue(1'b1, SZ_BYTE, 1'b0, 32'h32, 32'h99, 32'h0, 1'b0, 1'b1);
    issue(1'b0, SZ_BYTE, 1'b1, 32'h32, 32'h0, ref_load(SZ_BYTE, 1'b1, 32'h32), 1'b0, 1'b1);
    issue(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, ref_load(SZ_WORD, 1'b0, 32'h30), 1'b0, 1'b1);
    ref_store(SZ_HALF, 32'h32, 32'h1234);
    issue(1'b1, SZ_HALF, 1'b0, 32'h32, 32'h1234, 32'h0, 1'b0, 1'b1);
    issue(1'b0, SZ_HALF, 1'b0, 32'h32, 32'h0, ref_load(SZ_HALF, 1'b0, 32'h32), 1'b0, 1'b1);
    issue(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, ref_load(SZ_WORD, 1'b0, 32'h30), 1'b0, 1'b1);

    drain = 0;
    while (sb_q.size() > 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d responses outstanding, required 0", sb_q.size());
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit for the MEM stage, sitting directly upstream of the word-addressed data memory. It accepts one load or store per request from the EX/MEM pipeline register and drives the memory's word port. It performs byte and halfword extraction with sign or zero extension on loads. Sub-word stores are done as a two-cycle read-modify-write, because the memory only writes whole words.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width; must equal the memory's address width.
- DATA_WIDTH, 32, word width; only 32 is supported, elaborate-time error otherwise.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  pipeline presents a memory op this cycle
- req_ready  out  1  unit can accept; transfer when req_valid && req_ready
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-justified (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle pulse: load data or store completion or error
- rsp_rdata  out  DATA_WIDTH  extended load result; 0 for stores and errors
- rsp_err  out  1  qualified by rsp_valid: misaligned or reserved-size request
- mem_addr  out  ADDR_WIDTH  word-aligned address to memory (req_addr with [1:0] = 00)
- mem_cs  out  1  memory select
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_WIDTH  word to write
- mem_rdata  in  DATA_WIDTH  combinational read data from memory

## Operation
- Byte order is big-endian. Byte at addr[1:0]=00 is bits [31:24]. Halfword at addr[1]=0 is [31:16].
- Alignment check: a halfword needs addr[0]=0 and a word needs addr[1:0]=00. A failing request makes no memory access (cs=0, we=0). It gets rsp_valid=1 and rsp_err=1 in the next cycle.
- FSM states are IDLE and RMW_WR.
- IDLE: req_ready=1. On an accepted request:
  - Load: cs=1, we=0 this cycle. The extracted, extended mem_rdata is registered into rsp_rdata and rsp_valid pulses next cycle. Stay in IDLE.
  - Word store: cs=1, we=1, mem_wdata=req_wdata this cycle. rsp_valid pulses next cycle. Stay in IDLE.
  - Byte or half store: cs=1, we=0 this cycle. mem_rdata is merged with the shifted store data into a merge register, along with the word address. Go to RMW_WR.
- RMW_WR: req_ready=0. cs=1, we=1, mem_addr = latched address, mem_wdata = merge register. Return to IDLE next cycle. rsp_valid pulses the cycle after the write.
- No valid request in IDLE: cs=0, we=0, mem_addr holds its last value.
- mem_cs, mem_we, mem_addr and mem_wdata are combinational from the state and the request. req_ready depends only on the state.

## Timing
- Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, merge register=0. req_ready=1 and mem_we=0 during reset.
- Latency from acceptance to rsp_valid:
  - Load: 1 cycle.
  - Word store: 1 cycle.
  - Misaligned request: 1 cycle.
  - Sub-word store: 2 cycles, with the memory written at the end of cycle 1.
- Throughput is one request per cycle, except that a sub-word store blocks acceptance for 1 cycle.
- req_valid held while req_ready=0 is not accepted. Its fields must stay stable until acceptance.
- An asynchronous reset during RMW_WR abandons the write: mem_we falls immediately and no response is issued. Memory keeps its prior word.
- Back-to-back case: a load to the same word issued in the cycle right after RMW_WR sees the new merged data. The write commits on the edge that ends RMW_WR.

## Structure
- Shared package mips_mem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the state enum {IDLE, RMW_WR};
  - the alignment-check function.
- Sub-module byte_lane_align is purely combinational. It provides load extract/extend (addr[1:0], size, signed, word → result) and store merge (addr[1:0], size, old word, wdata → new word). It is unit-testable in isolation.

## Test plan
- Memory word 0x10 = 0x11223344. lb at 0x11 → rsp_rdata 0x00000022. lhu at 0x12 → 0x00003344. lw at 0x10 → 0x11223344. Each gives rsp_valid one cycle after acceptance.
- Word 0x20 = 0x80FF7F01. lb at 0x20 → 0xFFFFFF80. lbu at 0x20 → 0x00000080. lh at 0x20 → 0xFFFF80FF.
- sb 0xAB at 0x13 onto 0x11223344: req_ready=0 for one cycle, then a lw at 0x10 → 0x112233AB. sh 0xBEEF at 0x10 → 0xBEEF33AB.
- lh at 0x11, sw at 0x12 and req_size=11: each gives rsp_err=1 with rsp_rdata=0, and mem_we/mem_cs stay 0 throughout. The memory word is unchanged.
- Assert rst_n=0 mid-RMW_WR of sb 0x55 at 0x10: mem_we drops at once, no rsp_valid, word stays 0x11223344. After release, req_ready=1.
- Back-to-back stream sw, lb, sb, lw to the same word: all responses are ordered and values match a reference byte-array model.
